// File: rtl/video_frame_capture.sv
// Sink-side frame grabber: recovers x/y from DE/VSYNC and writes one frame.
// Build option: CAPTURE_CONT_EN keeps capturing every frame after one arm.
module video_frame_capture #(
  parameter int DATA_W   = 8,
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720,
  parameter int ADDR_W   = 20
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              de,
  input  logic              arm,
  output logic              busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [11:0]       x,
  output logic [11:0]       y,
  output logic              frame_done,
  output logic [11:0]       frame_cnt,
  output logic              err_hlen,
  output logic              err_vlen,
  output logic              err_ovf
);

  localparam int NPIX = H_ACTIVE * V_ACTIVE;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  localparam logic [11:0] H_LEN = 12'(H_ACTIVE);
  localparam logic [11:0] V_LEN = 12'(V_ACTIVE);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FB,
    CAPTURE,
    DONE
  } state_t;

  state_t state;

  logic              vs_d;
  logic              de_d;
  logic              hs_d;
  logic [ADDR_W-1:0] addr_cnt;
  logic              full;
  logic [11:0]       run_cnt;
  logic [11:0]       line_cnt;

  logic              fb;
  logic              le;
  logic [11:0]       lines_at_fb;
  logic              unused_hs;

  assign fb = ~vsync & vs_d;
  assign le = ~de & de_d;

  // A line that ends on the very edge of the frame boundary still counts.
  assign lines_at_fb = line_cnt + {11'd0, le};

  assign unused_hs = hs_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      vs_d       <= 1'b0;
      de_d       <= 1'b0;
      hs_d       <= 1'b0;
      addr_cnt   <= '0;
      full       <= 1'b0;
      run_cnt    <= '0;
      line_cnt   <= '0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
      frame_cnt  <= '0;
      err_hlen   <= 1'b0;
      err_vlen   <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      vs_d       <= vsync;
      de_d       <= de;
      hs_d       <= hsync;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (arm) begin
            state    <= WAIT_FB;
            busy     <= 1'b1;
            err_hlen <= 1'b0;
            err_vlen <= 1'b0;
            err_ovf  <= 1'b0;
          end
        end

        WAIT_FB: begin
          if (fb) begin
            state    <= CAPTURE;
            addr_cnt <= '0;
            full     <= 1'b0;
            run_cnt  <= '0;
            line_cnt <= '0;
            wr_addr  <= '0;
          end
        end

        CAPTURE: begin
          if (fb) begin
            if (le && run_cnt != H_LEN) err_hlen <= 1'b1;
            if (lines_at_fb != V_LEN) err_vlen <= 1'b1;
            frame_done <= 1'b1;
            frame_cnt  <= frame_cnt + 12'd1;
            state      <= DONE;
`ifndef CAPTURE_CONT_EN
            busy       <= 1'b0;
`endif
          end else begin
            if (de) begin
              run_cnt <= run_cnt + 12'd1;
              if (full) begin
                err_ovf <= 1'b1;
              end else begin
                wr_en    <= 1'b1;
                wr_addr  <= addr_cnt;
                wr_data  <= in_data;
                x        <= run_cnt;
                y        <= line_cnt;
                addr_cnt <= addr_cnt + 1'b1;
                if (addr_cnt == LAST) full <= 1'b1;
              end
            end
            if (le) begin
              if (run_cnt != H_LEN) err_hlen <= 1'b1;
              line_cnt <= line_cnt + 12'd1;
              run_cnt  <= '0;
            end
          end
        end

        DONE: begin
`ifdef CAPTURE_CONT_EN
          state    <= CAPTURE;
          addr_cnt <= '0;
          full     <= 1'b0;
          run_cnt  <= '0;
          line_cnt <= '0;
          wr_addr  <= '0;
`else
          state    <= IDLE;
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_video_frame_capture.sv
// Directed bench for video_frame_capture with an 8x4 frame geometry.
// Each task drives one scenario and checks its own expectations inline.
module tb_video_frame_capture;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        hsync = 1'b0;
  logic        vsync = 1'b0;
  logic        de = 1'b0;
  logic        arm = 1'b0;
  logic        busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [11:0] x;
  logic [11:0] y;
  logic        frame_done;
  logic [11:0] frame_cnt;
  logic        err_hlen;
  logic        err_vlen;
  logic        err_ovf;

  int errors = 0;
  int checks = 0;

  int wcount = 0;
  int data_bad = 0;
  int seq_bad = 0;
  int fd_count = 0;
  logic [4:0]  exp_addr = '0;
  logic [4:0]  last_addr = '0;
  logic [11:0] last_x = '0;
  logic [11:0] last_y = '0;

  video_frame_capture #(
    .DATA_W  (8),
    .H_ACTIVE(8),
    .V_ACTIVE(4),
    .ADDR_W  (5)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_data   (in_data),
    .hsync     (hsync),
    .vsync     (vsync),
    .de        (de),
    .arm       (arm),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .x         (x),
    .y         (y),
    .frame_done(frame_done),
    .frame_cnt (frame_cnt),
    .err_hlen  (err_hlen),
    .err_vlen  (err_vlen),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  // Write-port observer; pixel data is driven equal to its frame index.
  always @(negedge clk) begin
    if (!nrst) begin
      exp_addr = '0;
    end else begin
      if (wr_en) begin
        wcount++;
        if (wr_data !== {3'b000, wr_addr}) data_bad++;
        if (wr_addr !== exp_addr) seq_bad++;
        exp_addr  = exp_addr + 5'd1;
        last_addr = wr_addr;
        last_x    = x;
        last_y    = y;
      end
      if (frame_done) begin
        fd_count++;
        exp_addr = '0;
      end
    end
  end

  task automatic step(input logic v, input logic h, input logic d,
                      input logic [7:0] dat, input logic a);
    @(negedge clk);
    vsync   = v;
    hsync   = h;
    de      = d;
    in_data = dat;
    arm     = a;
  endtask

  task automatic pulse_arm();
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  // Leading vsync pulse, then nlines lines of 8 pixels (7 on short_line).
  task automatic send_frame(input int nlines, input int short_line,
                            input int arm_line);
    int pix;
    pix = 0;
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    for (int l = 0; l < nlines; l++) begin
      int len;
      len = (l == short_line) ? 7 : 8;
      step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      for (int p = 0; p < len; p++) begin
        step(1'b0, 1'b0, 1'b1, 8'(pix), (l == arm_line) && (p == 3));
        pix++;
      end
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    end
  endtask

  task automatic close_frame(input logic exp_done, input logic exp_busy);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    @(negedge clk);
    checks++;
    if (frame_done !== exp_done) begin
      errors++;
      $display("FAIL close_frame_done: got %b want %b", frame_done, exp_done);
    end
    checks++;
    if (busy !== exp_busy) begin
      errors++;
      $display("FAIL close_busy: got %b want %b", busy, exp_busy);
    end
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, wr_en, frame_done, err_hlen, err_vlen, err_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b want 000000",
               {busy, wr_en, frame_done, err_hlen, err_vlen, err_ovf});
    end
    checks++;
    if ({wr_addr, wr_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_wr: got addr=%0d data=%0d want 0", wr_addr, wr_data);
    end
    checks++;
    if ({x, y, frame_cnt} !== 36'd0) begin
      errors++;
      $display("FAIL reset_xy_cnt: got x=%0d y=%0d cnt=%0d want 0", x, y, frame_cnt);
    end
    nrst = 1'b1;
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b want 0", busy);
    end
  endtask

  task automatic test_clean();
    int w0, f0, d0, s0;
    w0 = wcount; f0 = fd_count; d0 = data_bad; s0 = seq_bad;
    pulse_arm();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_busy_after_arm: got %b want 1", busy);
    end
    send_frame(4, -1, -1);
    close_frame(1'b1, 1'b0);
    checks++;
    if (wcount - w0 !== 32) begin
      errors++;
      $display("FAIL clean_writes: got %0d want 32", wcount - w0);
    end
    checks++;
    if ((data_bad - d0) + (seq_bad - s0) !== 0) begin
      errors++;
      $display("FAIL clean_addr_data: got %0d bad want 0",
               (data_bad - d0) + (seq_bad - s0));
    end
    checks++;
    if ({last_addr, last_x, last_y} !== {5'd31, 12'd7, 12'd3}) begin
      errors++;
      $display("FAIL clean_last: got a=%0d x=%0d y=%0d want a=31 x=7 y=3",
               last_addr, last_x, last_y);
    end
    checks++;
    if (fd_count - f0 !== 1) begin
      errors++;
      $display("FAIL clean_done_pulses: got %0d want 1", fd_count - f0);
    end
    checks++;
    if (frame_cnt !== 12'd1) begin
      errors++;
      $display("FAIL clean_frame_cnt: got %0d want 1", frame_cnt);
    end
    checks++;
    if ({err_hlen, err_vlen, err_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL clean_errs: got %b want 000", {err_hlen, err_vlen, err_ovf});
    end
  endtask

  task automatic test_short_line();
    int w0, f0;
    w0 = wcount; f0 = fd_count;
    pulse_arm();
    send_frame(4, 1, -1);
    close_frame(1'b1, 1'b0);
    checks++;
    if (wcount - w0 !== 31) begin
      errors++;
      $display("FAIL short_writes: got %0d want 31", wcount - w0);
    end
    checks++;
    if ({err_hlen, err_vlen, err_ovf} !== 3'b100) begin
      errors++;
      $display("FAIL short_errs: got %b want 100", {err_hlen, err_vlen, err_ovf});
    end
    checks++;
    if (fd_count - f0 !== 1 || frame_cnt !== 12'd2) begin
      errors++;
      $display("FAIL short_done: got pulses=%0d cnt=%0d want 1 and 2",
               fd_count - f0, frame_cnt);
    end
    checks++;
    if (last_addr !== 5'd30) begin
      errors++;
      $display("FAIL short_last_addr: got %0d want 30", last_addr);
    end
  endtask

  task automatic test_overflow();
    int w0, d0, s0;
    w0 = wcount; d0 = data_bad; s0 = seq_bad;
    pulse_arm();
    checks++;
    if (err_hlen !== 1'b0) begin
      errors++;
      $display("FAIL ovf_arm_clears: got err_hlen=%b want 0", err_hlen);
    end
    send_frame(5, -1, -1);
    close_frame(1'b1, 1'b0);
    checks++;
    if (wcount - w0 !== 32) begin
      errors++;
      $display("FAIL ovf_writes: got %0d want 32", wcount - w0);
    end
    checks++;
    if ({err_hlen, err_vlen, err_ovf} !== 3'b011) begin
      errors++;
      $display("FAIL ovf_errs: got %b want 011", {err_hlen, err_vlen, err_ovf});
    end
    checks++;
    if (wr_addr !== 5'd31) begin
      errors++;
      $display("FAIL ovf_addr_hold: got %0d want 31", wr_addr);
    end
    checks++;
    if ((data_bad - d0) + (seq_bad - s0) !== 0 || frame_cnt !== 12'd3) begin
      errors++;
      $display("FAIL ovf_seq_cnt: got bad=%0d cnt=%0d want 0 and 3",
               (data_bad - d0) + (seq_bad - s0), frame_cnt);
    end
  endtask

  task automatic test_arm_midframe();
    int w0, f0, d0, s0;
    w0 = wcount; f0 = fd_count; d0 = data_bad; s0 = seq_bad;
    send_frame(4, -1, 1);
    checks++;
    if (wcount - w0 !== 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_wait: got writes=%0d busy=%b want 0 and 1",
               wcount - w0, busy);
    end
    send_frame(4, -1, 1);
    close_frame(1'b1, 1'b0);
    send_frame(4, -1, -1);
    close_frame(1'b0, 1'b0);
    checks++;
    if (wcount - w0 !== 32) begin
      errors++;
      $display("FAIL mid_writes: got %0d want 32", wcount - w0);
    end
    checks++;
    if (fd_count - f0 !== 1 || frame_cnt !== 12'd4) begin
      errors++;
      $display("FAIL mid_done: got pulses=%0d cnt=%0d want 1 and 4",
               fd_count - f0, frame_cnt);
    end
    checks++;
    if ({err_hlen, err_vlen, err_ovf} !== 3'b000) begin
      errors++;
      $display("FAIL mid_errs: got %b want 000", {err_hlen, err_vlen, err_ovf});
    end
    checks++;
    if ((data_bad - d0) + (seq_bad - s0) !== 0) begin
      errors++;
      $display("FAIL mid_addr_data: got %0d bad want 0",
               (data_bad - d0) + (seq_bad - s0));
    end
  endtask

  task automatic test_reset_midframe();
    int w0, f0;
    pulse_arm();
    send_frame(2, -1, -1);
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd16, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd17, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd18, 1'b0);
    @(negedge clk);
    nrst = 1'b0;
    #1;
    checks++;
    if ({busy, wr_en, frame_done, err_hlen, err_vlen, err_ovf} !== 6'b0) begin
      errors++;
      $display("FAIL rstmid_flags: got %b want 000000",
               {busy, wr_en, frame_done, err_hlen, err_vlen, err_ovf});
    end
    checks++;
    if ({wr_addr, wr_data, x, y, frame_cnt} !== 49'd0) begin
      errors++;
      $display("FAIL rstmid_values: got a=%0d d=%0d x=%0d y=%0d cnt=%0d want 0",
               wr_addr, wr_data, x, y, frame_cnt);
    end
    step(1'b0, 1'b0, 1'b1, 8'd20, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd21, 1'b0);
    nrst = 1'b1;
    w0 = wcount; f0 = fd_count;
    step(1'b0, 1'b0, 1'b1, 8'd22, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'd23, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    close_frame(1'b0, 1'b0);
    send_frame(4, -1, -1);
    close_frame(1'b0, 1'b0);
    checks++;
    if (wcount - w0 !== 0 || fd_count - f0 !== 0) begin
      errors++;
      $display("FAIL rstmid_quiet: got writes=%0d pulses=%0d want 0",
               wcount - w0, fd_count - f0);
    end
    checks++;
    if (busy !== 1'b0 || frame_cnt !== 12'd0) begin
      errors++;
      $display("FAIL rstmid_state: got busy=%b cnt=%0d want 0 and 0",
               busy, frame_cnt);
    end
  endtask

`ifdef CAPTURE_CONT_EN
  task automatic test_continuous();
    int w0, f0, d0, s0;
    w0 = wcount; f0 = fd_count; d0 = data_bad; s0 = seq_bad;
    pulse_arm();
    send_frame(4, -1, -1);
    send_frame(4, -1, -1);
    send_frame(4, -1, -1);
    close_frame(1'b1, 1'b1);
    checks++;
    if (fd_count - f0 !== 3 || frame_cnt !== 12'd3) begin
      errors++;
      $display("FAIL cont_done: got pulses=%0d cnt=%0d want 3 and 3",
               fd_count - f0, frame_cnt);
    end
    checks++;
    if (wcount - w0 !== 96) begin
      errors++;
      $display("FAIL cont_writes: got %0d want 96", wcount - w0);
    end
    checks++;
    if ((data_bad - d0) + (seq_bad - s0) !== 0) begin
      errors++;
      $display("FAIL cont_addr_restart: got %0d bad want 0",
               (data_bad - d0) + (seq_bad - s0));
    end
    checks++;
    if ({busy, err_hlen, err_vlen, err_ovf} !== 4'b1000) begin
      errors++;
      $display("FAIL cont_busy_errs: got %b want 1000",
               {busy, err_hlen, err_vlen, err_ovf});
    end
  endtask
`endif

  initial begin
    test_reset();
`ifdef CAPTURE_CONT_EN
    test_continuous();
`else
    test_clean();
    test_short_line();
    test_overflow();
    test_arm_midframe();
    test_reset_midframe();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
